// File: rtl/mips16_pkg.sv
// Shared encodings for the mips16 data-memory path: owner ids, arbiter
// states and default memory geometry.
package mips16_pkg;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_HOST_LOCK = 1'b1
  } arb_state_e;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if #(
  parameter int AW = mips16_pkg::DMEM_AW,
  parameter int DW = mips16_pkg::DMEM_DW
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          lock_active;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata, lock_active,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, lock_active,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: bit 0 = CPU, bit 1 = host; on a tie the
// requester that did not win last time is granted.
module rr_arb2
  import mips16_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last == OWN_HOST)) gnt[0] = 1'b1;
    else if (req[1])                              gnt[1] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU LW/SW port and the host
// debug port: round-robin grant, bounded host lock, 1-cycle read return.
module dmem_arbiter
  import mips16_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int LOCK_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e    state_q, state_d;
  owner_e        last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          relock_blk_q, relock_blk_d;
  logic          rd_pending_q, rd_pending_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  logic [1:0]    rr_gnt;
  logic          cpu_gnt, host_gnt;
  logic          cpu_rvalid, host_rvalid;
  logic [CW-1:0] cnt_inc;

  rr_arb2 u_rr (
    .req  ({bus.host_req, bus.cpu_req}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // While locked the host wins outright; the CPU only gets the idle slot.
  always_comb begin
    cpu_gnt  = rr_gnt[0];
    host_gnt = rr_gnt[1];
    if (state_q == ST_HOST_LOCK) begin
      host_gnt = bus.host_req;
      cpu_gnt  = bus.cpu_req & ~bus.host_req;
    end
  end

  assign cnt_inc = lock_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_d       = last_q;
    relock_blk_d = relock_blk_q;
    if (cpu_gnt)  last_d = OWN_CPU;
    if (host_gnt) last_d = OWN_HOST;
    if (cpu_gnt || !bus.cpu_req) relock_blk_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (host_gnt && bus.host_lock && !relock_blk_q) begin
        state_d    = ST_HOST_LOCK;
        lock_cnt_d = CW'(1);
      end
    end else begin
      if (!bus.host_req || !bus.host_lock) begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end else if (cnt_inc == CW'(LOCK_MAX)) begin
        // Forced release: hold off re-locking until the CPU gets a turn.
        state_d      = ST_IDLE;
        lock_cnt_d   = '0;
        relock_blk_d = 1'b1;
      end else begin
        lock_cnt_d = cnt_inc;
      end
    end
  end

  // Read return: owner captured at grant, data taken from memory next cycle.
  always_comb begin
    rd_pending_d = (cpu_gnt & ~bus.cpu_we) | (host_gnt & ~bus.host_we);
    rd_owner_d   = rd_owner_q;
    if (rd_pending_d) rd_owner_d = host_gnt ? OWN_HOST : OWN_CPU;
    cpu_rvalid   = rd_pending_q & (rd_owner_q == OWN_CPU);
    host_rvalid  = rd_pending_q & (rd_owner_q == OWN_HOST);
    cpu_rdata_d  = cpu_rvalid  ? bus.mem_rdata : cpu_rdata_q;
    host_rdata_d = host_rvalid ? bus.mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= OWN_HOST;
      lock_cnt_q   <= '0;
      relock_blk_q <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWN_CPU;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      lock_cnt_q   <= lock_cnt_d;
      relock_blk_q <= relock_blk_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.cpu_rdata   = cpu_rdata_d;
  assign bus.host_rdata  = host_rdata_d;
  assign bus.lock_active = (state_q == ST_HOST_LOCK);

  always_comb begin
    bus.mem_en    = cpu_gnt | host_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table for grants/mux outputs, a
// read-return scoreboard, and hand sequences for reset-mid-read.
module tb_dmem_arbiter;
  import mips16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(16)) bus ();
  dmem_arbiter #(.AW(8), .DW(16), .LOCK_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Simple 1-cycle-latency memory, reloaded with a known pattern on reset.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= {8'(i), 8'(i)};
      mem[5] <= 16'h1234;
      bus.mem_rdata <= 16'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        own;
    logic [15:0] d;
  } sb_t;
  sb_t sbq[$];

  // Every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_rvalid && bus.host_rvalid) begin
        chk("both_rvalid", 32'(2'b11), 32'(2'b00));
      end else if (bus.cpu_rvalid || bus.host_rvalid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", 32'(bus.host_rvalid), 32'(2'b10));
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("rd_owner", 32'(bus.host_rvalid), 32'(e.own));
          chk("rd_data", 32'(bus.host_rvalid ? bus.host_rdata : bus.cpu_rdata), 32'(e.d));
        end
      end
    end
  end

  typedef struct {
    logic cr, cw; logic [7:0] ca; logic [15:0] cd;
    logic hr, hw, hl; logic [7:0] ha; logic [15:0] hd;
    logic gc, gh, lk; logic [15:0] rd;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t v(logic cr, logic cw, logic [7:0] ca, logic [15:0] cd,
                             logic hr, logic hw, logic hl, logic [7:0] ha, logic [15:0] hd,
                             logic gc, logic gh, logic lk, logic [15:0] rd);
    vec_t r;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.hr = hr; r.hw = hw; r.hl = hl; r.ha = ha; r.hd = hd;
    r.gc = gc; r.gh = gh; r.lk = lk; r.rd = rd;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    bus.cpu_req = r.cr; bus.cpu_we = r.cw; bus.cpu_addr = r.ca; bus.cpu_wdata = r.cd;
    bus.host_req = r.hr; bus.host_we = r.hw; bus.host_lock = r.hl;
    bus.host_addr = r.ha; bus.host_wdata = r.hd;
  endtask

  task automatic push_sb(input logic own, input logic [15:0] d);
    sb_t e;
    e.own = own; e.d = d;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(v(0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t idle;

  initial begin
    idle = v(0,0,0,0, 0,0,0,0,0, 0,0,0,0);
    // Alternating contention right after reset: CPU first.
    for (int k = 0; k < 2; k++) begin
      vt.push_back(v(1,1,8'h10,16'hAAAA, 1,0,0,8'h20,16'h0, 1,0,0,16'h0));
      vt.push_back(v(1,1,8'h10,16'hAAAA, 1,0,0,8'h20,16'h0, 0,1,0,16'h2020));
    end
    vt.push_back(idle);
    vt.push_back(v(1,0,8'h05,16'h0, 0,0,0,8'h00,16'h0, 1,0,0,16'h1234));
    vt.push_back(idle);
    // Locked host burst against a waiting CPU read.
    for (int i = 0; i < 8; i++)
      vt.push_back(v(1,0,8'h02,16'h0, 1,1,1,8'(48+i),16'(16'hB000+i), 0,1,(i != 0),16'h0));
    vt.push_back(v(1,0,8'h02,16'h0, 1,1,1,8'h38,16'hB008, 1,0,0,16'h0202));
    vt.push_back(v(1,0,8'h02,16'h0, 1,1,1,8'h38,16'hB008, 0,1,0,16'h0));
    vt.push_back(v(1,0,8'h02,16'h0, 1,1,1,8'h39,16'hB009, 0,1,1,16'h0));
    vt.push_back(v(1,0,8'h02,16'h0, 1,1,1,8'h3A,16'hB00A, 0,1,1,16'h0));
    vt.push_back(v(1,0,8'h02,16'h0, 0,0,0,8'h00,16'h0, 1,0,1,16'h0202));
    vt.push_back(idle);
    // Read back burst data, then back-to-back host/CPU reads.
    vt.push_back(v(0,0,8'h00,16'h0, 1,0,0,8'h30,16'h0, 0,1,0,16'hB000));
    vt.push_back(v(0,0,8'h00,16'h0, 1,0,0,8'h01,16'h0, 0,1,0,16'h0101));
    vt.push_back(v(1,0,8'h02,16'h0, 0,0,0,8'h00,16'h0, 1,0,0,16'h0202));
    vt.push_back(idle);
    // host_lock with no host_req must not lock.
    vt.push_back(v(1,0,8'h05,16'h0, 0,0,1,8'h44,16'h0, 1,0,0,16'h1234));
    vt.push_back(v(0,0,8'h00,16'h0, 0,0,1,8'h00,16'h0, 0,0,0,16'h0));
    vt.push_back(idle);

    do_reset();
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'(0));
    chk("rst_host_gnt", 32'(bus.host_gnt), 32'(0));
    chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_rvalid", 32'({bus.cpu_rvalid, bus.host_rvalid}), 32'(0));
    chk("rst_rdata", 32'({bus.cpu_rdata, bus.host_rdata}), 32'(0));
    chk("rst_lock", 32'(bus.lock_active), 32'(0));
    @(posedge clk); #1;

    foreach (vt[n]) begin
      vec_t r;
      logic [7:0]  ea;
      logic [15:0] ed;
      logic        ew;
      r = vt[n];
      drive(r);
      ea = r.gc ? r.ca : (r.gh ? r.ha : 8'h0);
      ed = r.gc ? r.cd : (r.gh ? r.hd : 16'h0);
      ew = r.gc ? r.cw : (r.gh ? r.hw : 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", n), 32'(bus.cpu_gnt), 32'(r.gc));
      chk($sformatf("v%0d_host_gnt", n), 32'(bus.host_gnt), 32'(r.gh));
      chk($sformatf("v%0d_lock", n), 32'(bus.lock_active), 32'(r.lk));
      chk($sformatf("v%0d_stall", n), 32'(bus.cpu_stall), 32'(r.cr & ~r.gc));
      chk($sformatf("v%0d_mem_en", n), 32'(bus.mem_en), 32'(r.gc | r.gh));
      chk($sformatf("v%0d_mem_we", n), 32'(bus.mem_we), 32'(ew));
      chk($sformatf("v%0d_mem_addr", n), 32'(bus.mem_addr), 32'(ea));
      chk($sformatf("v%0d_mem_wdata", n), 32'(bus.mem_wdata), 32'(ed));
      if (r.gc && !r.cw) push_sb(OWN_CPU, r.rd);
      if (r.gh && !r.hw) push_sb(OWN_HOST, r.rd);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hold_cpu_rdata", 32'(bus.cpu_rdata), 32'(16'h1234));
    chk("hold_host_rdata", 32'(bus.host_rdata), 32'(16'h0101));
    @(posedge clk); #1;

    // Reset in the cycle after a CPU read grant drops the read.
    drive(v(1,0,8'h05,16'h0, 0,0,0,8'h00,16'h0, 0,0,0,16'h0));
    @(negedge clk);
    chk("mr_cpu_gnt", 32'(bus.cpu_gnt), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    drive(idle);
    @(negedge clk);
    chk("mr_rvalid_in_rst", 32'(bus.cpu_rvalid), 32'(0));
    chk("mr_rdata_in_rst", 32'(bus.cpu_rdata), 32'(0));
    chk("mr_lock_in_rst", 32'(bus.lock_active), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_rvalid_after", 32'(bus.cpu_rvalid), 32'(0));
    @(posedge clk); #1;
    drive(v(1,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 0,0,0,16'h0));
    @(negedge clk);
    chk("mr_first_cpu", 32'({bus.cpu_gnt, bus.host_gnt}), 32'(2'b10));
    if (bus.cpu_gnt) push_sb(OWN_CPU, 16'h0101);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("mr_then_host", 32'({bus.cpu_gnt, bus.host_gnt}), 32'(2'b01));
    if (bus.host_gnt) push_sb(OWN_HOST, 16'h0202);
    @(posedge clk); #1;
    drive(idle);
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store port (LW/SW) and a host debug/program port driven from the TinyTapeout pins.
- Arbitrates round-robin each cycle. Supports a bounded host lock for burst access.
- Routes 1-cycle-latency read data back to the owner.
- Drives a stall signal that holds the single-cycle CPU's PC while its memory request is pending.

Parameters:
- AW, 8, memory word-address width
- DW, 16, data width
- LOCK_MAX, 8, max consecutive locked host grants before forced release (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU store data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- host_req  in  1  host access request
- host_we  in  1  1=write, 0=read
- host_lock  in  1  request bus lock (burst)
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DW  host read data
- lock_active  out  1  FSM in HOST_LOCK
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid cycle after mem_en & ~mem_we

Behaviour:
- Clock and reset: one clock clk; reset rst asynchronous, active-high.
- Reset values:
  - state=IDLE, last_winner=HOST (CPU wins first tie), lock_cnt=0.
  - rd_pending=0, rd_owner=CPU.
  - All rvalid=0 and rdata=0.
  - gnt/mem outputs are combinational, so they are 0 with no requests.
- Grant path: combinational, same cycle as req.
  - Exactly one gnt at most per cycle.
  - mem_en=cpu_gnt|host_gnt; mem_we/addr/wdata muxed from the winner.
  - When there is no grant, mem_addr/mem_wdata are 0.
- State IDLE:
  - Single requester: granted.
  - Both requesting: the requester ≠ last_winner is granted.
  - last_winner updates on every grant.
  - If host granted with host_lock=1: next state HOST_LOCK, lock_cnt=1.
- State HOST_LOCK:
  - Host has absolute priority while host_req=1. Each host grant increments lock_cnt.
  - Exit to IDLE on any of:
    - host_lock=0 at a grant (that grant still given);
    - host_req=0 (no grant that cycle; CPU may be granted);
    - the grant that makes lock_cnt==LOCK_MAX.
  - On exit by LOCK_MAX: last_winner=HOST, so a waiting CPU wins the next cycle.
  - A forced release cannot re-lock until the CPU has been granted or cpu_req=0 for one cycle.
  - lock_active=1 exactly while state==HOST_LOCK.
- Read return:
  - Registered. A read grant in cycle N sets rd_pending=1 and rd_owner.
  - In cycle N+1: owner's rvalid=1 and owner's rdata=mem_rdata. The other requester's rvalid=0.
  - rdata holds its last value when rvalid=0. Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalid with correct owner interleave.
- Starvation bound:
  - CPU waits ≤1 cycle against an unlocked host.
  - CPU waits ≤LOCK_MAX cycles against a locked host.
- Boundaries:
  - Request inputs must be held stable until gnt.
  - Changing addr before gnt is allowed; the value at grant is used.
  - Reset mid-read drops the in-flight read (no rvalid after reset).
  - host_lock without host_req is ignored.

Decomposition:
- Shared package mips16_pkg holds:
  - owner encoding (OWN_CPU=0, OWN_HOST=1);
  - arbiter state encoding (IDLE, HOST_LOCK);
  - default AW/DW constants, shared with the CPU's data memory.
- One natural sub-module: rr_arb2, a two-way round-robin pick (req[1:0], last → gnt[1:0]).
- FSM, lock counter and read-return pipeline stay in dmem_arbiter.

Test Plan:
- Sequence:
  1. Reset.
  2. cpu_req read addr 0x05 alone.
  3. mem_rdata=0x1234 next cycle.
- Required: cpu_gnt same cycle, mem_addr=0x05, then cpu_rvalid=1 with cpu_rdata=0x1234, host_rvalid=0.
- Both req every cycle, host_lock=0, CPU write 0x10/0xAAAA, host read 0x20 → grants alternate CPU,HOST,CPU,...; first grant CPU after reset; cpu_stall=1 on host cycles.
- Host burst: host_req=host_lock=1 for 12 cycles, LOCK_MAX=8, cpu_req=1 throughout → 8 consecutive host_gnt, lock_active high for them; cycle 9 cpu_gnt, then lock re-entry only after CPU served.
- Back-to-back reads: host read 0x01 then CPU read 0x02 with mem_rdata 0x0101, 0x0202 → host_rvalid/0x0101 then cpu_rvalid/0x0202 on consecutive cycles.
- Assert rst the cycle after a CPU read grant → cpu_rvalid stays 0, state=IDLE; after release, simultaneous requests grant CPU first.
